tm1638_key_reader: RTL and testbench

TM1638_KEY_READER -- requirements
Module: tm1638_key_reader

---
 rtl/tm1638_key_reader.sv | 189 ++++++++++++++++++
 tb/tb_tm1638_key_reader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_key_reader.sv
// tm1638_key_reader: issues one TM1638 key-scan transaction per start pulse.
// The transaction is: strobe low, send read command 0x42 LSB first, turnaround
// wait, clock in 32 key bits LSB first, then release the strobe. When the scan
// completes, the four scan bytes appear on raw and the decoded keys on keys.
// Optional build macro TM1638_KEY_DEBOUNCE_EN: keys change only when two
// consecutive completed scans return identical raw data.
//
// Handshake: start is a single-cycle request that is honoured only while
// busy=0; valid is a single-cycle pulse marking the cycle raw/keys change.
// state_dbg exposes the FSM state encoding for external checkers.
module tm1638_key_reader #(
  parameter int CLK_DIV     = 4,
  parameter int WAIT_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        valid,
  output logic [31:0] raw,
  output logic [7:0]  keys,
  output logic        stb,
  output logic        tm_clk,
  output logic        dio_out,
  output logic        dio_oe,
  input  logic        dio_in,
  output logic [2:0]  state_dbg
);

  localparam logic [7:0] CMD_READ   = 8'h42;
  localparam logic [9:0] HALF       = 10'(CLK_DIV);
  localparam logic [9:0] HALF_LAST  = 10'(CLK_DIV - 1);
  localparam logic [9:0] BIT_LAST   = 10'(2 * CLK_DIV - 1);
  localparam logic [9:0] WAIT_LAST  = 10'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    STB_SETUP   = 3'd1,
    CMD_SEND    = 3'd2,
    WAIT_READ   = 3'd3,
    DATA_READ   = 3'd4,
    STB_RELEASE = 3'd5
  } state_t;

  state_t      state, state_next;
  logic [9:0]  cnt, cnt_next;
  logic [4:0]  bit_idx, bit_next;
  logic [31:0] shadow, shadow_next;
  logic        done;

`ifdef TM1638_KEY_DEBOUNCE_EN
  logic [31:0] prev_raw;
`endif

  // Key matrix layout: bit 0 and bit 4 of each scan byte carry one key each.
  function automatic logic [7:0] decode_keys(input logic [31:0] r);
    decode_keys = {r[28], r[20], r[12], r[4], r[24], r[16], r[8], r[0]};
  endfunction

  // Next-state, counters, read shadow and bus pin levels.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    bit_next    = bit_idx;
    shadow_next = shadow;
    done        = 1'b0;
    stb         = 1'b1;
    tm_clk      = 1'b1;
    dio_out     = 1'b0;
    dio_oe      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = STB_SETUP;
          cnt_next   = '0;
          bit_next   = '0;
        end
      end
      STB_SETUP: begin
        stb = 1'b0;
        if (cnt == HALF_LAST) begin
          cnt_next   = '0;
          state_next = CMD_SEND;
        end else begin
          cnt_next = cnt + 10'd1;
        end
      end
      CMD_SEND: begin
        stb     = 1'b0;
        dio_oe  = 1'b1;
        tm_clk  = (cnt >= HALF);
        dio_out = CMD_READ[bit_idx[2:0]];
        if (cnt == BIT_LAST) begin
          cnt_next = '0;
          if (bit_idx == 5'd7) begin
            bit_next   = '0;
            state_next = WAIT_READ;
          end else begin
            bit_next = bit_idx + 5'd1;
          end
        end else begin
          cnt_next = cnt + 10'd1;
        end
      end
      WAIT_READ: begin
        stb = 1'b0;
        if (cnt == WAIT_LAST) begin
          cnt_next   = '0;
          state_next = DATA_READ;
        end else begin
          cnt_next = cnt + 10'd1;
        end
      end
      DATA_READ: begin
        stb    = 1'b0;
        tm_clk = (cnt >= HALF);
        // Sample on the first high cycle; the chip drives data after the fall.
        if (cnt == HALF) shadow_next[bit_idx] = dio_in;
        if (cnt == BIT_LAST) begin
          cnt_next = '0;
          if (bit_idx == 5'd31) begin
            bit_next   = '0;
            state_next = STB_RELEASE;
          end else begin
            bit_next = bit_idx + 5'd1;
          end
        end else begin
          cnt_next = cnt + 10'd1;
        end
      end
      STB_RELEASE: begin
        if (cnt == HALF_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
          done       = 1'b1;
        end else begin
          cnt_next = cnt + 10'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        bit_next   = '0;
      end
    endcase
  end

  // FSM state, counters and read shadow register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shadow  <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_next;
      shadow  <= shadow_next;
    end
  end

  // Publish a completed scan; only finished scans ever reach raw/keys.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      raw   <= '0;
      keys  <= '0;
`ifdef TM1638_KEY_DEBOUNCE_EN
      prev_raw <= '0;
`endif
    end else begin
      valid <= done;
      if (done) begin
        raw <= shadow;
`ifdef TM1638_KEY_DEBOUNCE_EN
        if (shadow == prev_raw) keys <= decode_keys(shadow);
        prev_raw <= shadow;
`else
        keys <= decode_keys(shadow);
`endif
      end
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_tm1638_key_reader.sv
// Directed testbench for tm1638_key_reader with a behavioural TM1638 bus model.
module tb_tm1638_key_reader;

  localparam int CD  = 2;
  localparam int WC  = 4;
  localparam int LAT = 82 * CD + WC + 1;  // 169

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic        valid;
  logic [31:0] raw;
  logic [7:0]  keys;
  logic        stb;
  logic        tm_clk;
  logic        dio_out;
  logic        dio_oe;
  logic        dio_in = 1'b0;
  logic [2:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  tm1638_key_reader #(.CLK_DIV(CD), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .valid(valid),
    .raw(raw), .keys(keys), .stb(stb), .tm_clk(tm_clk), .dio_out(dio_out),
    .dio_oe(dio_oe), .dio_in(dio_in), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // TM1638 bus model: drives key bits after each falling tm_clk, captures the command.
  logic [31:0] scan_data = '0;
  logic [7:0]  cmd_cap   = '0;
  int fall_cnt = 0;
  int rise_cnt = 0;
  int stb_rise = 0;
  int oe_err   = 0;

  always @(negedge stb) begin
    fall_cnt = 0;
    rise_cnt = 0;
    cmd_cap  = '0;
  end

  always @(negedge tm_clk) begin
    if (!stb) begin
      if (fall_cnt >= 8 && fall_cnt < 40) dio_in = scan_data[fall_cnt-8];
      fall_cnt++;
    end
  end

  always @(posedge tm_clk) begin
    if (!stb) begin
      if (rise_cnt < 8) begin
        cmd_cap[rise_cnt] = dio_out;
        if (!dio_oe) oe_err++;
      end else if (dio_oe) begin
        oe_err++;
      end
      rise_cnt++;
    end
  end

  always @(posedge stb) stb_rise++;

  // reference model of the key outputs
  logic [31:0] m_prev = '0;
  logic [7:0]  m_keys = '0;

  function automatic logic [7:0] ref_decode(input logic [31:0] r);
    logic [7:0] k;
    k = '0;
    for (int n = 0; n < 4; n++) begin
      k[n]   = r[8*n];
      k[n+4] = r[8*n+4];
    end
    return k;
  endfunction

  task automatic model_scan(input logic [31:0] r);
`ifdef TM1638_KEY_DEBOUNCE_EN
    if (r == m_prev) m_keys = ref_decode(r);
    m_prev = r;
`else
    m_keys = ref_decode(r);
`endif
  endtask

  task automatic model_reset();
    m_prev = '0;
    m_keys = '0;
  endtask

  // driver: one scan; optional start noise while busy, optional chaining
  int stb_base, oe_base, busy_first, busy_last;
  task automatic do_scan(input logic [31:0] data, input bit noisy, input bit chain,
                         output int lat, output int nv);
    scan_data = data;
    stb_base  = stb_rise;
    oe_base   = oe_err;
    lat = 0;
    nv  = 0;
    busy_first = 0;
    busy_last  = 0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= LAT + 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1) busy_first = int'(busy);
      if (c == LAT - 1) busy_last = int'(busy);
      if (valid) begin
        nv++;
        if (lat == 0) lat = c;
        if (chain) break;
      end
      if (noisy && busy && (c % 9 == 4)) start = 1'b1;
      if (lat != 0 && c >= lat + 20) break;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  int lat, nv, lat2, nv2, vcount;
  bit reached;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stb",    32'(stb), 32'd1);
    check("rst_tm_clk", 32'(tm_clk), 32'd1);
    check("rst_dio_oe", 32'(dio_oe), 32'd0);
    check("rst_dio_out", 32'(dio_out), 32'd0);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_valid",  32'(valid), 32'd0);
    check("rst_raw",    raw, 32'h0);
    check("rst_keys",   32'(keys), 32'h0);
    rst = 1'b0;
    model_reset();

    // basic scan: bytes 0x01,0x10,0x00,0x11
    do_scan(32'h1100_1001, 1'b0, 1'b0, lat, nv);
    model_scan(32'h1100_1001);
    check("a_latency", 32'(lat), 32'(LAT));
    check("a_nvalid",  32'(nv), 32'd1);
    check("a_cmd",     32'(cmd_cap), 32'h42);
    check("a_rises",   32'(rise_cnt), 32'd40);
    check("a_stb_low", 32'(stb_rise - stb_base), 32'd1);
    check("a_dio_oe",  32'(oe_err - oe_base), 32'd0);
    check("a_busy_first", 32'(busy_first), 32'd1);
    check("a_busy_last",  32'(busy_last), 32'd1);
    check("a_busy_idle",  32'(busy), 32'd0);
    check("a_raw",     raw, 32'h1100_1001);
    check("a_keys",    32'(keys), 32'(m_keys));

    // start pulses during busy must be ignored
    do_scan(32'h5A3C_0F81, 1'b1, 1'b0, lat, nv);
    model_scan(32'h5A3C_0F81);
    check("b_latency", 32'(lat), 32'(LAT));
    check("b_nvalid",  32'(nv), 32'd1);
    check("b_cmd",     32'(cmd_cap), 32'h42);
    check("b_rises",   32'(rise_cnt), 32'd40);
    check("b_stb_low", 32'(stb_rise - stb_base), 32'd1);
    check("b_raw",     raw, 32'h5A3C_0F81);
    check("b_keys",    32'(keys), 32'(m_keys));
    check("b_busy_idle", 32'(busy), 32'd0);

    // identical scans after reset; second start lands on the valid cycle
    pulse_reset();
    do_scan(32'h0000_0001, 1'b0, 1'b1, lat, nv);
    model_scan(32'h0000_0001);
    check("c1_latency", 32'(lat), 32'(LAT));
    check("c1_raw",     raw, 32'h0000_0001);
    check("c1_keys",    32'(keys), 32'(m_keys));
    do_scan(32'h0000_0001, 1'b0, 1'b0, lat2, nv2);
    model_scan(32'h0000_0001);
    check("c2_latency", 32'(lat2), 32'(LAT));
    check("c2_nvalid",  32'(nv2), 32'd1);
    check("c2_raw",     raw, 32'h0000_0001);
    check("c2_keys",    32'(keys), 32'h01);

    // reset during the 10th data bit aborts the scan without a valid
    scan_data = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (fall_cnt >= 18) begin
        reached = 1'b1;
        break;
      end
    end
    check("d_reach_bit10", 32'(reached), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("d_stb",    32'(stb), 32'd1);
    check("d_tm_clk", 32'(tm_clk), 32'd1);
    check("d_dio_oe", 32'(dio_oe), 32'd0);
    check("d_raw",    raw, 32'h0);
    check("d_keys",   32'(keys), 32'h0);
    check("d_busy",   32'(busy), 32'd0);
    check("d_state",  32'(state_dbg), 32'd0);
    rst = 1'b0;
    model_reset();
    vcount = 0;
    for (int c = 0; c < LAT + 20; c++) begin
      @(negedge clk);
      if (valid) vcount++;
    end
    check("d_no_valid", 32'(vcount), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
